// File: rtl/booth_product_register.sv
// booth_product_register
// Product/multiplier register for a signed sequential Booth multiplier.
// It holds {upper accumulator, lower multiplier, guard bit} and an extension
// bit that supplies the arithmetic fill on each shift. It also counts the
// remaining shift steps, so the controller needs no counter of its own.
module booth_product_register #(
  parameter int n     = 8,
  parameter int radix = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       controlledRstSignal,
  input  logic                       load,
  input  logic [n-1:0]               selectedLowerLoad,
  input  logic                       loadUpper,
  input  logic [n-1:0]               aluResult,
  input  logic                       carryOut,
  input  logic                       shiftRight,
  output logic [2*n:0]               product,
  output logic [2:0]                 boothBits,
  output logic [$clog2(n+1)-1:0]     stepCount,
  output logic                       busy,
  output logic                       done
);

  // Step size in bits and the number of shift steps in one multiply.
  localparam int                S     = (radix == 4) ? 2 : 1;
  localparam int                CW    = $clog2(n + 1);
  localparam logic [CW-1:0]     STEPS = CW'(n / S);

  logic [2*n:0]        r_product;
  logic                r_ext;
  logic [CW-1:0]       r_step;
  logic                r_done;

  logic [n-1:0]        w_upper_sel;
  logic                w_ext_sel;
  logic signed [2*n+1:0] w_vec;
  logic signed [2*n+1:0] w_shifted;
  logic                w_busy;

  // Build the shift vector; a concurrent loadUpper feeds the fresh ALU result
  // straight into the shift, which gives the single-cycle add-and-shift path.
  always_comb begin
    w_upper_sel = r_product[2*n:n+1];
    w_ext_sel   = r_ext;
    if (loadUpper) begin
      w_upper_sel = aluResult;
      w_ext_sel   = carryOut;
    end else begin
      w_upper_sel = r_product[2*n:n+1];
      w_ext_sel   = r_ext;
    end
    w_vec     = {w_ext_sel, w_upper_sel, r_product[n:0]};
    w_shifted = w_vec >>> S;
    w_busy    = (r_step != '0);
  end

  // State update: clear beats load, which beats the ALU write / shift step.
  always_ff @(posedge clk) begin
    if (rst || controlledRstSignal) begin
      r_product <= '0;
      r_ext     <= 1'b0;
      r_step    <= '0;
      r_done    <= 1'b0;
    end else if (load) begin
      r_product <= {{n{1'b0}}, selectedLowerLoad, 1'b0};
      r_ext     <= 1'b0;
      r_step    <= STEPS;
      r_done    <= 1'b0;
    end else if (shiftRight && w_busy) begin
      r_product <= w_shifted[2*n:0];
      r_ext     <= w_ext_sel;
      r_step    <= r_step - CW'(1);
      if (r_step == CW'(1)) begin
        r_done <= 1'b1;
      end else begin
        r_done <= r_done;
      end
    end else if (loadUpper) begin
      r_product[2*n:n+1] <= aluResult;
      r_ext              <= carryOut;
    end else begin
      r_product <= r_product;
      r_ext     <= r_ext;
      r_step    <= r_step;
      r_done    <= r_done;
    end
  end

  // Booth recoding window taken straight from the registered product.
  always_comb begin
    boothBits = 3'b000;
    if (radix == 4) begin
      boothBits = r_product[2:0];
    end else begin
      boothBits = {1'b0, r_product[1:0]};
    end
  end

  assign product   = r_product;
  assign stepCount = r_step;
  assign busy      = w_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_booth_product_register.sv
// Directed bench for booth_product_register: a radix-2 and a radix-4 instance
// (n = 8) receive the same stimulus and are checked against hand-computed values.
module tb_booth_product_register;

  logic        clk;
  logic        rst;
  logic        crst;
  logic        load;
  logic [7:0]  lower_in;
  logic        load_upper;
  logic [7:0]  alu;
  logic        carry;
  logic        shift;

  logic [16:0] p2, p4;
  logic [2:0]  b2, b4;
  logic [3:0]  s2, s4;
  logic        busy2, busy4, done2, done4;

  int errors = 0;
  int checks = 0;

  booth_product_register #(.n(8), .radix(2)) dut2 (
    .clk(clk), .rst(rst), .controlledRstSignal(crst), .load(load),
    .selectedLowerLoad(lower_in), .loadUpper(load_upper), .aluResult(alu),
    .carryOut(carry), .shiftRight(shift), .product(p2), .boothBits(b2),
    .stepCount(s2), .busy(busy2), .done(done2)
  );

  booth_product_register #(.n(8), .radix(4)) dut4 (
    .clk(clk), .rst(rst), .controlledRstSignal(crst), .load(load),
    .selectedLowerLoad(lower_in), .loadUpper(load_upper), .aluResult(alu),
    .carryOut(carry), .shiftRight(shift), .product(p4), .boothBits(b4),
    .stepCount(s4), .busy(busy4), .done(done4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; crst = 1'b0; load = 1'b0; load_upper = 1'b0; shift = 1'b0;
  endtask

  initial begin
    lower_in = 8'hFF; alu = 8'hFF; carry = 1'b1;
    rst = 1'b1; crst = 1'b1; load = 1'b1; load_upper = 1'b1; shift = 1'b1;
    tick(); tick();
    check("rst_p2", 32'(p2), 32'h0);
    check("rst_p4", 32'(p4), 32'h0);
    check("rst_b4", 32'(b4), 32'h0);
    check("rst_s2", 32'(s2), 32'h0);
    check("rst_busy_done", 32'({busy2, done2, busy4, done4}), 32'h0);

    // Released with only shiftRight: not busy, so ignored.
    idle(); shift = 1'b1; tick();
    check("idle_shift_p2", 32'(p2), 32'h0);
    check("idle_busy_done", 32'({busy2, done2, busy4, done4}), 32'h0);

    // Load 0x0A.
    idle(); load = 1'b1; lower_in = 8'h0A; tick();
    check("load_p2", 32'(p2), 32'h00014);
    check("load_s2", 32'(s2), 32'd8);
    check("load_s4", 32'(s4), 32'd4);
    check("load_busy", 32'({busy2, busy4}), 32'h3);

    // loadUpper 0x80 / carry 1.
    idle(); load_upper = 1'b1; alu = 8'h80; carry = 1'b1; tick();
    check("ldup_p2", 32'(p2), 32'h10014);
    check("ldup_s2", 32'(s2), 32'd8);

    // First shift.
    idle(); shift = 1'b1; tick();
    check("sh1_p2", 32'(p2), 32'h1800A);
    check("sh1_s2", 32'(s2), 32'd7);
    check("sh1_p4", 32'(p4), 32'h1C005);
    check("sh1_b4", 32'(b4), 32'h5);
    check("sh1_s4", 32'(s4), 32'd3);
    check("sh1_b2", 32'(b2), 32'h2);

    // Shifts 2..3: radix-4 not yet done.
    tick(); tick();
    check("sh3_done4", 32'(done4), 32'h0);
    tick();
    check("sh4_p4", 32'(p4), 32'h1FF00);
    check("sh4_done4", 32'({done4, busy4}), 32'h2);
    check("sh4_s2", 32'(s2), 32'd4);
    check("sh4_done2", 32'(done2), 32'h0);
    tick(); tick(); tick(); tick();
    check("sh8_p2", 32'(p2), 32'h1FF00);
    check("sh8_done2", 32'({done2, busy2}), 32'h2);
    check("sh8_s2", 32'(s2), 32'd0);
    tick();
    check("sh9_p2", 32'(p2), 32'h1FF00);
    check("sh9_p4", 32'(p4), 32'h1FF00);
    check("sh9_done", 32'({done2, done4}), 32'h3);

    // loadUpper with shift while not busy: only the upper write applies.
    idle(); load_upper = 1'b1; shift = 1'b1; alu = 8'h55; carry = 1'b0; tick();
    check("ldup_idle_p2", 32'(p2), 32'h0AB00);
    check("ldup_idle_done", 32'({done2, s2}), 32'h10);

    // Combined add-and-shift on a fresh load of 0x0A.
    idle(); load = 1'b1; lower_in = 8'h0A; tick();
    idle(); load_upper = 1'b1; shift = 1'b1; alu = 8'h7F; carry = 1'b0; tick();
    check("addsh_p2", 32'(p2), 32'h07F0A);
    check("addsh_p4", 32'(p4), 32'h03F85);
    check("addsh_s2", 32'(s2), 32'd7);
    check("addsh_done", 32'({done2, done4}), 32'h0);
    idle(); shift = 1'b1; tick();
    check("ext0_p2", 32'(p2), 32'h03F85);
    check("ext0_p4", 32'(p4), 32'h00FE1);

    // Abort mid-multiply with the controller clear at stepCount 3.
    idle(); load = 1'b1; lower_in = 8'h0A; tick();
    idle(); shift = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("pre_abort_s2", 32'(s2), 32'd3);
    idle(); crst = 1'b1; shift = 1'b1; load_upper = 1'b1; tick();
    check("abort_p2", 32'(p2), 32'h0);
    check("abort_p4", 32'(p4), 32'h0);
    check("abort_state", 32'({s2, busy2, done2, s4, busy4, done4}), 32'h0);

    // Load with concurrent shift/loadUpper: load only.
    idle(); load = 1'b1; shift = 1'b1; load_upper = 1'b1; lower_in = 8'hC3; alu = 8'h11; tick();
    check("ldsh_p2", 32'(p2), 32'h00186);
    check("ldsh_p4", 32'(p4), 32'h00186);
    check("ldsh_s2", 32'(s2), 32'd8);
    check("ldsh_s4", 32'(s4), 32'd4);

    idle(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
